// File: rtl/stacker_pkg.sv
// Shared types and geometry defaults for the stacker game blocks.
package stacker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_RESOLVE,
    ST_PLACE,
    ST_OVER
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int COORD_W = 9;
  localparam int SIZE_W  = 4;
  // One bit wider than a coordinate so edge + step never wraps.
  localparam int CALC_W  = COORD_W + 1;

  localparam int X_MAX_DEF = 320;
  localparam int UNIT_DEF  = 8;
  localparam int ROWS_DEF  = 15;

endpackage

// File: rtl/block_slider_move_tick.sv
// move_tick: enabled divider emitting a one-cycle tick every `period` cycles.
module move_tick #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  // NOTE: resetn is synchronous, so it only appears inside the clocked branch,
  // never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking updates let every register see pre-edge values.
      if (cnt_q >= period - ONE) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + ONE;
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/block_slider.sv
// block_slider: sweeps the moving block, resolves a drop against the previous
// block and advances rows. BLOCK_SLIDER_SPEEDUP_EN shortens the tick every 4 rows.
module block_slider
  import stacker_pkg::*;
#(
  parameter int X_MAX     = X_MAX_DEF,
  parameter int UNIT      = UNIT_DEF,
  parameter int INIT_SIZE = 4,
  parameter int ROWS      = ROWS_DEF,
  parameter int SPEED_DIV = 2500000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               stop_req,
  output logic [COORD_W-1:0] curr_start,
  output logic [COORD_W-1:0] curr_end,
  output logic [SIZE_W-1:0]  curr_size,
  output logic [COORD_W-1:0] prev_start,
  output logic [COORD_W-1:0] prev_end,
  output logic [SIZE_W-1:0]  prev_size,
  output logic [SIZE_W-1:0]  row,
  output logic               place_valid,
  output logic               game_over,
  output logic               win
);

  localparam logic [COORD_W-1:0] UNIT_C   = COORD_W'(UNIT);
  localparam logic [CALC_W-1:0]  UNIT_X   = CALC_W'(UNIT);
  localparam logic [CALC_W-1:0]  X_LAST   = CALC_W'(X_MAX - 1);
  localparam logic [COORD_W-1:0] INIT_END = COORD_W'(INIT_SIZE * UNIT - 1);
  localparam logic [SIZE_W-1:0]  INIT_SZ  = SIZE_W'(INIT_SIZE);
  localparam logic [SIZE_W-1:0]  LAST_ROW = SIZE_W'(ROWS - 1);
  localparam logic [31:0]        DIV_C    = 32'(SPEED_DIV);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [COORD_W-1:0] curr_start_q, curr_start_d, curr_end_q, curr_end_d;
  logic [COORD_W-1:0] prev_start_q, prev_start_d, prev_end_q, prev_end_d;
  logic [SIZE_W-1:0]  curr_size_q, curr_size_d, prev_size_q, prev_size_d;
  logic [SIZE_W-1:0]  row_q, row_d;
  logic               place_valid_q, place_valid_d;
  logic               game_over_q, game_over_d, win_q, win_d;
  logic               stop_q;

  logic               stop_edge, tick, tick_clr;
  logic [31:0]        period_raw, period;
  logic [COORD_W-1:0] ov_start, ov_end;
  logic [CALC_W-1:0]  ov_len;
  logic               miss;

  assign stop_edge = stop_req & ~stop_q;

`ifdef BLOCK_SLIDER_SPEEDUP_EN
  // row is 4 bits wide, so row/4 tops out at 3 without an explicit clamp.
  assign period_raw = DIV_C >> row_q[3:2];
`else
  assign period_raw = DIV_C;
`endif
  assign period = (period_raw == '0) ? 32'd1 : period_raw;

  move_tick #(.CNT_W(32)) u_move_tick (
    .clk    (clk),
    .resetn (resetn),
    .en     (state_q == ST_MOVE),
    .clr    (tick_clr),
    .period (period),
    .tick   (tick)
  );

  // Overlap of the frozen block with the last placed one; row 0 stands alone.
  always_comb begin
    if (row_q == '0) begin
      ov_start = curr_start_q;
      ov_end   = curr_end_q;
      miss     = 1'b0;
    end else begin
      ov_start = (curr_start_q > prev_start_q) ? curr_start_q : prev_start_q;
      ov_end   = (curr_end_q < prev_end_q) ? curr_end_q : prev_end_q;
      miss     = (curr_start_q > prev_end_q) || (curr_end_q < prev_start_q);
    end
    ov_len = {1'b0, ov_end} - {1'b0, ov_start} + CALC_W'(1);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d       = state_q;
    dir_d         = dir_q;
    curr_start_d  = curr_start_q;
    curr_end_d    = curr_end_q;
    curr_size_d   = curr_size_q;
    prev_start_d  = prev_start_q;
    prev_end_d    = prev_end_q;
    prev_size_d   = prev_size_q;
    row_d         = row_q;
    place_valid_d = 1'b0;
    game_over_d   = game_over_q;
    win_d         = win_q;
    tick_clr      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d      = ST_MOVE;
          dir_d        = DIR_RIGHT;
          row_d        = '0;
          curr_start_d = '0;
          curr_end_d   = INIT_END;
          curr_size_d  = INIT_SZ;
          prev_start_d = '0;
          prev_end_d   = '0;
          prev_size_d  = '0;
          game_over_d  = 1'b0;
          win_d        = 1'b0;
          tick_clr     = 1'b1;
        end
      end

      ST_MOVE: begin
        if (stop_edge) begin
          state_d = ST_RESOLVE;
        end else if (tick) begin
          // Bounce: a blocked step reverses and moves the other way at once.
          if ((dir_q == DIR_RIGHT) ? (({1'b0, curr_end_q} + UNIT_X) <= X_LAST)
                                   : (curr_start_q < UNIT_C)) begin
            curr_start_d = curr_start_q + UNIT_C;
            curr_end_d   = curr_end_q + UNIT_C;
            dir_d        = DIR_RIGHT;
          end else begin
            curr_start_d = curr_start_q - UNIT_C;
            curr_end_d   = curr_end_q - UNIT_C;
            dir_d        = DIR_LEFT;
          end
        end
      end

      ST_RESOLVE: begin
        if (miss) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
          win_d       = 1'b0;
        end else begin
          state_d = ST_PLACE;
        end
      end

      ST_PLACE: begin
        prev_start_d  = ov_start;
        prev_end_d    = ov_end;
        prev_size_d   = SIZE_W'(ov_len / UNIT_X);
        curr_size_d   = SIZE_W'(ov_len / UNIT_X);
        place_valid_d = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
          win_d       = 1'b1;
          curr_end_d  = curr_start_q + COORD_W'(ov_len - CALC_W'(1));
        end else begin
          state_d      = ST_MOVE;
          row_d        = row_q + SIZE_W'(1);
          dir_d        = DIR_RIGHT;
          curr_start_d = '0;
          curr_end_d   = COORD_W'(ov_len - CALC_W'(1));
          tick_clr     = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      dir_q         <= DIR_RIGHT;
      curr_start_q  <= '0;
      curr_end_q    <= '0;
      curr_size_q   <= '0;
      prev_start_q  <= '0;
      prev_end_q    <= '0;
      prev_size_q   <= '0;
      row_q         <= '0;
      place_valid_q <= 1'b0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
      stop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      curr_start_q  <= curr_start_d;
      curr_end_q    <= curr_end_d;
      curr_size_q   <= curr_size_d;
      prev_start_q  <= prev_start_d;
      prev_end_q    <= prev_end_d;
      prev_size_q   <= prev_size_d;
      row_q         <= row_d;
      place_valid_q <= place_valid_d;
      game_over_q   <= game_over_d;
      win_q         <= win_d;
      stop_q        <= stop_req;
    end
  end

  assign curr_start  = curr_start_q;
  assign curr_end    = curr_end_q;
  assign curr_size   = curr_size_q;
  assign prev_start  = prev_start_q;
  assign prev_end    = prev_end_q;
  assign prev_size   = prev_size_q;
  assign row         = row_q;
  assign place_valid = place_valid_q;
  assign game_over   = game_over_q;
  assign win         = win_q;

endmodule

// File: tb/tb_block_slider.sv
// Bench for block_slider: pixel-level game model checked every cycle, plus
// hand-computed expectations at the interesting moments of three short games.
module tb_block_slider;

  localparam int X_MAX     = 320;
  localparam int UNIT      = 8;
  localparam int INIT_SIZE = 4;
  localparam int ROWS      = 3;
  localparam int SPEED_DIV = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       stop_req = 1'b0;
  logic [8:0] curr_start, curr_end, prev_start, prev_end;
  logic [3:0] curr_size, prev_size, row;
  logic       place_valid, game_over, win;

  int n_checks = 0;
  int n_fail   = 0;

  block_slider #(
    .X_MAX(X_MAX), .UNIT(UNIT), .INIT_SIZE(INIT_SIZE), .ROWS(ROWS), .SPEED_DIV(SPEED_DIV)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop_req(stop_req),
    .curr_start(curr_start), .curr_end(curr_end), .curr_size(curr_size),
    .prev_start(prev_start), .prev_end(prev_end), .prev_size(prev_size),
    .row(row), .place_valid(place_valid), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: pixel position, a move countdown, and a drop age that counts
  // edges since the stop press (1 = judge overlap, 2 = place).
  int m_pos, m_size, m_dir, m_row, m_move_cnt, m_drop;
  int m_prev_lo, m_prev_hi, m_prev_size, m_ov_lo, m_ov_hi;
  bit m_active, m_loaded, m_over, m_win, m_pv, m_stop_last;

  task automatic model_step();
    int lo, hi;
    m_pv = 1'b0;
    if (!resetn) begin
      m_active = 0; m_loaded = 0; m_over = 0; m_win = 0; m_stop_last = 0;
      m_pos = 0; m_size = 0; m_dir = 1; m_row = 0; m_move_cnt = 0; m_drop = 0;
      m_prev_lo = 0; m_prev_hi = 0; m_prev_size = 0;
      return;
    end
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_loaded = 1; m_over = 0; m_win = 0;
        m_pos = 0; m_size = INIT_SIZE; m_dir = 1; m_row = 0; m_drop = 0;
        m_prev_lo = 0; m_prev_hi = 0; m_prev_size = 0;
        m_move_cnt = SPEED_DIV + 1;
      end
    end else if (m_drop == 0) begin
      if (stop_req && !m_stop_last) begin
        m_drop = 1;
      end else begin
        m_move_cnt--;
        if (m_move_cnt == 0) begin
          m_move_cnt = SPEED_DIV;
          if (m_dir > 0) begin
            if (m_pos + m_size * UNIT - 1 + UNIT <= X_MAX - 1) m_pos += UNIT;
            else begin m_dir = -1; m_pos -= UNIT; end
          end else begin
            if (m_pos >= UNIT) m_pos -= UNIT;
            else begin m_dir = 1; m_pos += UNIT; end
          end
        end
      end
    end else if (m_drop == 1) begin
      lo = m_pos;
      hi = m_pos + m_size * UNIT - 1;
      if (m_row != 0 && (lo > m_prev_hi || hi < m_prev_lo)) begin
        m_active = 0; m_over = 1; m_win = 0; m_drop = 0;
      end else begin
        if (m_row != 0) begin
          lo = (lo > m_prev_lo) ? lo : m_prev_lo;
          hi = (hi < m_prev_hi) ? hi : m_prev_hi;
        end
        m_ov_lo = lo; m_ov_hi = hi; m_drop = 2;
      end
    end else begin
      m_prev_lo = m_ov_lo; m_prev_hi = m_ov_hi;
      m_prev_size = (m_ov_hi - m_ov_lo + 1) / UNIT;
      m_size = m_prev_size;
      m_pv = 1; m_drop = 0;
      if (m_row == ROWS - 1) begin
        m_active = 0; m_over = 1; m_win = 1;
      end else begin
        m_row++; m_pos = 0; m_dir = 1; m_move_cnt = SPEED_DIV + 1;
      end
    end
    m_stop_last = stop_req;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("curr_start", curr_start, m_pos);
    check("curr_end", curr_end, m_loaded ? m_pos + m_size * UNIT - 1 : 0);
    check("curr_size", curr_size, m_size);
    check("prev_start", prev_start, m_prev_lo);
    check("prev_end", prev_end, m_prev_hi);
    check("prev_size", prev_size, m_prev_size);
    check("row", row, m_row);
    check("place_valid", place_valid, m_pv);
    check("game_over", game_over, m_over);
    check("win", win, m_win);
  end

  task automatic wait_pos(input int target, input int budget, output int waited);
    waited = 0;
    while (curr_start != 9'(target)) begin
      @(negedge clk);
      waited++;
      if (waited > budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_pos: curr_start=%0d never reached %0d", curr_start, target);
        return;
      end
    end
  endtask

  task automatic press_at(input int target);
    int w;
    wait_pos(target, 400, w);
    stop_req = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("rst_curr_end", curr_end, 0);
    check("rst_curr_size", curr_size, 0);
    resetn = 1'b1;

    // Game 1: full sweep with both bounces, a hit at 40, then a miss at 80.
    pulse_start();
    check("start_curr_size", curr_size, 4);
    check("start_curr_end", curr_end, 31);
    wait_pos(8, 20, w);
    wait_pos(16, 20, w);
    check("step_interval", w, 4);
    wait_pos(288, 400, w);
    check("right_wall_end", curr_end, 319);
    wait_pos(280, 20, w);
    check("right_bounce", w, 4);
    wait_pos(0, 400, w);
    wait_pos(8, 20, w);
    check("left_bounce", w, 4);
    press_at(40);
    repeat (3) @(negedge clk);
    check("r0_place_valid", place_valid, 1);
    check("r0_prev_start", prev_start, 40);
    check("r0_prev_end", prev_end, 71);
    check("r0_prev_size", prev_size, 4);
    check("r0_row", row, 1);
    check("r0_curr_start", curr_start, 0);
    repeat (10) @(negedge clk);
    check("held_stop_no_retrigger", curr_start, 16);
    stop_req = 1'b0;
    press_at(80);
    repeat (2) @(negedge clk);
    check("miss_game_over", game_over, 1);
    check("miss_win", win, 0);
    check("miss_prev_start", prev_start, 40);
    @(negedge clk);
    check("miss_no_place", place_valid, 0);
    stop_req = 1'b0;

    // Game 2: clip to two cells on row 1, aligned hit on the last row wins.
    pulse_start();
    check("restart_game_over", game_over, 0);
    press_at(40);
    repeat (3) @(negedge clk);
    stop_req = 1'b0;
    press_at(56);
    repeat (3) @(negedge clk);
    check("r1_prev_start", prev_start, 56);
    check("r1_prev_end", prev_end, 71);
    check("r1_prev_size", prev_size, 2);
    check("r1_curr_size", curr_size, 2);
    check("r1_curr_end", curr_end, 15);
    stop_req = 1'b0;
    press_at(56);
    repeat (3) @(negedge clk);
    check("win_place_valid", place_valid, 1);
    check("win_game_over", game_over, 1);
    check("win_win", win, 1);
    check("win_row_held", row, 2);
    stop_req = 1'b0;
    pulse_start();
    check("replay_row", row, 0);
    check("replay_prev_size", prev_size, 0);
    check("replay_win", win, 0);

    // Game 3: reset lands while the drop is being judged.
    press_at(24);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_curr_start", curr_start, 0);
    check("abort_place_valid", place_valid, 0);
    check("abort_curr_size", curr_size, 0);
    resetn = 1'b1;
    stop_req = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_stays_idle", place_valid, 0);
    check("abort_row", row, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/block_slider.md
# block_slider

Drives the moving block for the stacker game and resolves each drop. It sweeps the current block left and right across the row at a divided tick rate. On a stop press it freezes the block, clips it to its overlap with the previously placed block and publishes the clipped block as the new previous block. It then advances to the next row, or ends the game on a miss or on reaching the top. It sits between the button/tick logic and the VGA draw path, and is the producer of the block coordinates that the intersection check consumes.

## Interface
- X_MAX, 320: playfield width in pixels; legal x is 0..X_MAX-1
- UNIT, 8: pixels per block cell and per move step
- INIT_SIZE, 4: starting block size in cells (1..15); INIT_SIZE*UNIT ≤ X_MAX
- ROWS, 15: rows to fill for a win (2..15)
- SPEED_DIV, 2500000: clk cycles per move tick (≥ 2)
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins or restarts a game
- stop_req  in  1  synchronized button level; block rising-edge detects it
- curr_start  out  9  left pixel of moving block
- curr_end  out  9  right pixel of moving block, = curr_start + curr_size*UNIT - 1
- curr_size  out  4  moving block size in cells
- prev_start  out  9  left pixel of last placed block
- prev_end  out  9  right pixel of last placed block
- prev_size  out  4  last placed block size in cells
- row  out  4  index of row being played, 0 = bottom
- place_valid  out  1  one-cycle pulse when a block is placed; prev_* and row are already updated
- game_over  out  1  level; high in OVER state
- win  out  1  level; high in OVER state when all ROWS were placed

## Operation
- States: IDLE, MOVE, RESOLVE, PLACE, OVER.
- Reset:
  - All outputs 0, state IDLE, direction right, tick counter 0, stop edge register 0.
  - Reset mid-game aborts immediately with no place_valid.
- IDLE/OVER: on start, load row=0, curr_start=0, curr_size=INIT_SIZE, direction right, and clear game_over and win. Go to MOVE.
  - prev_* clear to 0 on start.
- MOVE, each tick:
  - Right: if curr_end+UNIT ≤ X_MAX-1, add UNIT; else flip to left and subtract UNIT. The block bounces and never rests a tick on the wall.
  - Left: if curr_start ≥ UNIT, subtract UNIT; else flip to right and add UNIT.
- MOVE, stop edge (stop_req=1, last sample 0): go to RESOLVE. The position does not move that cycle, even if a tick coincides. start is ignored outside IDLE/OVER.
- RESOLVE computes the overlap in 10-bit arithmetic:
  - ov_start = max(curr_start, prev_start); ov_end = min(curr_end, prev_end).
  - Row 0 has no previous block: ov = curr.
  - If curr_start > prev_end or curr_end < prev_start: miss. Go to OVER with game_over=1 and win=0; prev_* unchanged.
  - Otherwise go to PLACE.
- PLACE:
  - prev_start=ov_start, prev_end=ov_end, prev_size=(ov_end-ov_start+1)/UNIT; curr_size=prev_size.
  - Pulse place_valid.
  - If row == ROWS-1: go to OVER with game_over=1 and win=1; row is held.
  - Else: row+1, curr_start=0, direction right, tick counter 0, go to MOVE.
- Overlaps are always whole cells because all positions are multiples of UNIT. Size never reaches 0 on a hit.

## Timing
- Stop edge sampled in cycle N → RESOLVE in N+1 → PLACE in N+2 → place_valid high and new prev_*, curr_*, row visible in N+3. State is MOVE (or OVER) in N+3.
- On a miss, game_over is high from cycle N+2.
- Tick fires once per SPEED_DIV cycles in MOVE. Position updates on the cycle after the tick. The counter is frozen outside MOVE.
- All outputs are registered; none is combinational from inputs.
- A stop level held across rows does not re-trigger; a new rising edge is required.

## Configuration
- BLOCK_SLIDER_SPEEDUP_EN defined: tick period = SPEED_DIV >> min(row/4, 3), so play speeds up every 4 rows.
- Undefined: the period is fixed at SPEED_DIV.

## Structure
- stacker_pkg holds:
  - the state enum;
  - coordinate width 9 and size width 4;
  - the X_MAX, UNIT and ROWS defaults.
- Sub-module move_tick: a divider with enable, synchronous clear and period input, outputting a one-cycle tick.

## Test plan
- Reset then start, SPEED_DIV=4, hold stop low → curr_start steps 0,8,16… every 4 cycles; with INIT_SIZE=4 it reverses at curr_end=319 (curr_start=288) and returns to 0.
- Row 0 stop at curr_start=40 → place_valid in N+3, prev=40..71, prev_size=4, row=1, curr_start=0.
- Row 1 stop at curr_start=56 over prev 40..71 → prev=56..71, size 2, curr_size=2.
- Row 1 stop at curr_start=80 over prev 40..71 → game_over=1, win=0, no place_valid.
- ROWS=2, two aligned hits → second place_valid with game_over=1 and win=1; start afterward restarts at row 0.
- resetn low during RESOLVE → all outputs 0 next cycle, state IDLE, no place_valid.
